// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
// Parity modes, FSM encoding and frame configuration checks.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  function automatic int calc_div(
    input int clk_hz,
    input int baud
  );
    if (baud <= 0) return 0;
    return clk_hz / baud;
  endfunction

  function automatic bit cfg_ok(
    input int clk_hz,
    input int baud,
    input int data_bits,
    input int parity,
    input int stop_bits,
    input int fifo_depth
  );
    bit ok;
    ok = 1'b1;
    if (calc_div(clk_hz, baud) < 2) ok = 1'b0;
    if (data_bits < 5 || data_bits > 9) ok = 1'b0;
    if (parity < PAR_NONE || parity > PAR_EVEN) ok = 1'b0;
    if (stop_bits < 1 || stop_bits > 2) ok = 1'b0;
    if (fifo_depth < 2) ok = 1'b0;
    if ((fifo_depth & (fifo_depth - 1)) != 0) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags.
// Reads are first-word-fall-through from the head slot.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_next;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Next occupancy; simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_next = level;
    unique case ({do_push, do_pop})
      2'b10:   level_next = level + (AW+1)'(1);
      2'b01:   level_next = level - (AW+1)'(1);
      default: level_next = level;
    endcase
  end

  // Storage array; no reset needed since flags gate every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and flags registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_next;
      full  <= (level_next == FULL_LVL);
      empty <= (level_next == '0);
    end
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Buffered UART transmitter with configurable frame format.
// FIFO feeds a start/data/parity/stop shifter at DIV clocks per bit.
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [DATA_BITS-1:0]          i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_uart_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CW  = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CW-1:0] CNT_LOAD  = CW'(DIV - 1);
  localparam logic [BW-1:0] BITS_LOAD = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LOAD = BW'(STOP_BITS - 1);
  localparam logic          PAR_INV   = (PARITY == PAR_ODD);
  localparam bit            HAS_PAR   = (PARITY != PAR_NONE);

  if (!cfg_ok(CLK_FREQ_HZ, BAUD_RATE, DATA_BITS,
              PARITY, STOP_BITS, FIFO_DEPTH)) begin : g_cfg_err
    $error("uart_tx_fifo_param: illegal frame/FIFO configuration");
  end

  state_t               state;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 tx;

  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [DATA_BITS-1:0] fifo_q;
  logic [LW-1:0]        level;
  logic                 bit_done;
  logic                 frame_end;

  assign push      = i_valid & ~full;
  assign bit_done  = (baud_cnt == '0);
  assign frame_end = (state == S_STOP) & bit_done & (bit_cnt == '0);

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (push),
    .push_data (i_data),
    .pop       (pop),
    .pop_data  (fifo_q),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // Take the next word when idle or as the last stop bit ends.
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      if (state == S_IDLE) pop = 1'b1;
      if (frame_end)       pop = 1'b1;
    end
  end

  // Frame sequencer; the line is driven straight from a register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            state    <= S_START;
            tx       <= 1'b0;
            baud_cnt <= CNT_LOAD;
            shreg    <= fifo_q;
            par_bit  <= (^fifo_q) ^ PAR_INV;
          end
        end
        S_START: begin
          if (bit_done) begin
            state    <= S_DATA;
            tx       <= shreg[0];
            shreg    <= shreg >> 1;
            baud_cnt <= CNT_LOAD;
            bit_cnt  <= BITS_LOAD;
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        S_DATA: begin
          if (!bit_done) begin
            baud_cnt <= baud_cnt - CW'(1);
          end else if (bit_cnt != '0) begin
            bit_cnt  <= bit_cnt - BW'(1);
            tx       <= shreg[0];
            shreg    <= shreg >> 1;
            baud_cnt <= CNT_LOAD;
          end else if (HAS_PAR) begin
            state    <= S_PARITY;
            tx       <= par_bit;
            baud_cnt <= CNT_LOAD;
          end else begin
            state    <= S_STOP;
            tx       <= 1'b1;
            bit_cnt  <= STOP_LOAD;
            baud_cnt <= CNT_LOAD;
          end
        end
        S_PARITY: begin
          if (bit_done) begin
            state    <= S_STOP;
            tx       <= 1'b1;
            bit_cnt  <= STOP_LOAD;
            baud_cnt <= CNT_LOAD;
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        S_STOP: begin
          if (!bit_done) begin
            baud_cnt <= baud_cnt - CW'(1);
          end else if (bit_cnt != '0) begin
            bit_cnt  <= bit_cnt - BW'(1);
            baud_cnt <= CNT_LOAD;
          end else if (pop) begin
            state    <= S_START;
            tx       <= 1'b0;
            baud_cnt <= CNT_LOAD;
            shreg    <= fifo_q;
            par_bit  <= (^fifo_q) ^ PAR_INV;
          end else begin
            state    <= S_IDLE;
            tx       <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  assign o_uart_tx    = tx;
  assign o_ready      = ~full;
  assign o_fifo_level = level;
  assign o_busy       = (state != S_IDLE) | (level != '0);

endmodule

// File: doc/uart_tx_fifo_param.md
Name: uart_tx_fifo_param

Overview:
Parametrised, buffered UART transmitter. Successor to the fixed 8N1 emitter used by the core-score reporting path. Frame format is configurable: data width, parity and stop-bit count. A small synchronous FIFO decouples producers from the baud rate. It sits between any byte/word producer, such as a score or trace reporter, and the board TX pin.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency.
- BAUD_RATE, 115200, line rate. DIV = CLK_FREQ_HZ/BAUD_RATE (truncated). DIV>=2 required; elaboration error otherwise.
- DATA_BITS, 8, payload bits per frame, legal 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, legal 1 or 2.
- FIFO_DEPTH, 4, word buffer depth. Power of two, >=2.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_data  in  DATA_BITS  word to send.
- i_valid  in  1  producer has word.
- o_ready  out  1  FIFO can accept; registered.
- o_uart_tx  out  1  serial line, idle high; registered.
- o_busy  out  1  frame in progress or FIFO non-empty.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  words in FIFO (excludes word in shifter).

Behaviour:
- Reset (async assert, sync release):
  - o_uart_tx=1, o_ready=1, o_busy=0, o_fifo_level=0.
  - FSM=IDLE; baud counter cleared; FIFO pointers cleared.
  - Reset mid-frame aborts the frame immediately: line high, buffered words discarded.
- Handshake:
  - Word accepted on a rising edge with i_valid & o_ready.
  - o_ready = !full, registered. No combinational path from pop to ready, so a full FIFO reasserts o_ready the cycle after a pop.
  - Simultaneous push and pop with a non-full FIFO: level unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when FIFO non-empty, pop into shifter, load counter with DIV-1, go to START, drive line 0.
  - START: after DIV cycles go to DATA.
  - DATA: DATA_BITS bits, LSB first, DIV cycles each. Then go to PARITY if PARITY!=0, else STOP.
  - PARITY: bit = XOR of payload (even), inverted (odd); DIV cycles.
  - STOP: line 1 for STOP_BITS*DIV cycles.
  - End of STOP: if FIFO non-empty, pop and enter START on the next cycle (zero idle bits between frames); otherwise IDLE.
- Timing:
  - Every line bit lasts exactly DIV cycles.
  - Frame length = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*DIV cycles.
  - Latency: word accepted at edge k into an empty FIFO with FSM idle. Pop at edge k+1; o_uart_tx falls at edge k+1.
- Bit counter: width $clog2(DATA_BITS+1). Baud counter: width $clog2(DIV). Both count down and never wrap past zero.
- o_busy = (FSM!=IDLE) | (level!=0).
- Parity uses the captured payload, not i_data.
- i_data is ignored when not accepted.

Decomposition:
- Package uart_pkg holds:
  - parity constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2.
  - FSM state typedef (3-bit encoding).
  - function computing DIV plus the legality checks.
- One sub-module: uart_sync_fifo (parametrised width/depth, registered full/empty, level output), reusable for a future RX path.

Test Plan:
- DIV=10, 8N1, push 0xA5 once -> line low cycles 1..10; then 1,0,1,0,0,1,0,1 in 10-cycle slots; stop high 10 cycles; total 100 cycles; o_busy falls after stop.
- PARITY=2 with 0xA5 -> parity bit 0, frame 110 cycles. PARITY=1 with 0xA5 -> parity bit 1.
- DATA_BITS=7, PARITY=1, STOP_BITS=2, push 0x41 -> 7 data bits 1,0,0,0,0,0,1; parity 1; 20-cycle stop; frame 110 cycles.
- FIFO_DEPTH=4, i_valid held high with 6 distinct words -> exactly 5 accepted, o_fifo_level reaches 4, o_ready low. Frames emitted back-to-back with no idle gap, in order. 6th word accepted the cycle after the second pop.
- Assert i_rst_n low at cycle 35 of a frame with 2 words buffered -> o_uart_tx=1 in the same cycle (async). After release: o_fifo_level=0, o_ready=1, no further frames.
- Push 0x3C while i_valid toggles and o_ready is low -> words are never lost or duplicated; scoreboard checks each frame matches its accepted word.
